// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised word memory.
// Used by the top level and by the clear-sweep controller.
package mem_pkg;

  typedef enum logic {
    MS_IDLE  = 1'b0,
    MS_CLEAR = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear-sweep controller: owns the state, the sweep counter and busy.
// While sweeping it drives a zero-write enable and address to the array.
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              idle_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? MS_CLEAR : MS_IDLE;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        MS_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // Last word is being zeroed on this edge; requests accepted from next cycle.
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= MS_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (clear_i) begin
            state_q <= MS_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign idle_o     = (state_q == MS_IDLE);
  assign clr_we_o   = (state_q == MS_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/param_mem_mod.sv
// Single-port word memory with byte-masked writes, registered read with a
// valid strobe, and a hardware zero sweep after reset or on request.
module param_mem_mod
  import mem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [31:0]                  addr,
  input  logic [byte_count(DATA_W)-1:0] byte_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         busy
);

  localparam int BYTES = byte_count(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (DATA_W % 8 != 0) begin : g_bad_width
      $error("param_mem_mod: DATA_W must be a multiple of 8");
    end
  endgenerate

  logic              idle;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic [DATA_W-1:0] wr_mask;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  mem_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear),
    .busy_o     (busy),
    .idle_o     (idle),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign word_addr        = addr[ADDR_W-1:0];
  assign unused_addr_bits = ^addr[31:ADDR_W];
  // A clear request in IDLE takes priority over any access in the same cycle.
  assign accept           = idle && !clear && reset_n;

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
      assign wr_mask[gi*8 +: 8] = {8{byte_en[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (accept && wr_en) begin
      mem_q[word_addr] <= (mem_q[word_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Read-first: a same-cycle write to this word lands after the old value is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= accept && rd_en;
      if (accept && rd_en) begin
        rd_data_q <= mem_q[word_addr];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_mem_mod.sv
// Randomised self-checking bench for param_mem_mod (16 x 32 configuration),
// with a second instance that skips the reset-time sweep.
module tb_param_mem_mod;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          clear = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   addr = '0;
  logic [BW-1:0] byte_en = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy;

  logic          b_clear = 1'b0, b_rd_en = 1'b0, b_wr_en = 1'b0;
  logic [31:0]   b_addr = '0;
  logic [BW-1:0] b_byte_en = '0;
  logic [DW-1:0] b_wr_data = '0;
  logic [DW-1:0] b_rd_data;
  logic          b_rd_valid, b_busy;

  param_mem_mod #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .byte_en(byte_en), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  param_mem_mod #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset_n(reset_n), .clear(b_clear), .rd_en(b_rd_en), .wr_en(b_wr_en),
    .addr(b_addr), .byte_en(b_byte_en), .wr_data(b_wr_data),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < BW; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int a);
    addr = ($urandom() & 32'hFFFF_FFF0) | 32'(a);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    set_addr(a);
    wr_data = d;
    byte_en = be;
    wr_en   = 1'b1;
    cyc();
    wr_en   = 1'b0;
    model[a] = merge(model[a], d, be);
  endtask

  task automatic do_read(input int a, output logic [DW-1:0] d, output logic v);
    set_addr(a);
    rd_en = 1'b1;
    cyc();
    d = rd_data;
    v = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    logic [DW-1:0] d;
    logic v;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a, d, v);
      checks++;
      if (d !== model[a] || v !== 1'b1) begin
        errors++;
        $display("FAIL %s addr %0d: got data %h valid %b, expected %h valid 1", tag, a, d, v, model[a]);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: busy %b valid %b data %h, expected 1 0 0", busy, rd_valid, rd_data);
    end
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_noclear: got %b expected 0", b_busy);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL noclear_busy_after_reset: got %b expected 0", b_busy);
    end
    // Second instance is usable in the very first cycle after reset.
    b_addr = 32'd6; b_wr_data = 32'hA5A5_0101; b_byte_en = 4'hF; b_wr_en = 1'b1;
    count_busy(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL reset_busy_cycles: got %0d expected 16", n);
    end
    b_wr_en = 1'b0; b_rd_en = 1'b1;
    cyc();
    b_rd_en = 1'b0;
    checks++;
    if (b_rd_data !== 32'hA5A5_0101 || b_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL noclear_rw: got %h valid %b expected a5a50101 valid 1", b_rd_data, b_rd_valid);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    read_all_zero("reset_sweep_zero");
    cyc();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL idle_hold: valid %b data %h expected 0 00000000", rd_valid, rd_data);
    end
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] d;
    logic v;
    do_write(5, 32'hDEAD_BEEF, 4'b1111);
    do_write(5, 32'h0000_00AA, 4'b0001);
    do_read(5, d, v);
    checks++;
    if (d !== 32'hDEAD_BEAA || v !== 1'b1) begin
      errors++;
      $display("FAIL byte_merge: got %h valid %b expected deadbeaa valid 1", d, v);
    end
    do_write(5, 32'hFFFF_FFFF, 4'b0000);
    do_read(5, d, v);
    checks++;
    if (d !== 32'hDEAD_BEAA) begin
      errors++;
      $display("FAIL byte_en_zero: got %h expected deadbeaa", d);
    end
  endtask

  task automatic test_read_first();
    logic [DW-1:0] d;
    logic v;
    do_write(3, 32'hCAFE_F00D, 4'hF);
    set_addr(3);
    wr_data = 32'h1234_5678; byte_en = 4'hF;
    wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'hCAFE_F00D || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_first: got %h valid %b expected cafef00d valid 1", rd_data, rd_valid);
    end
    model[3] = 32'h1234_5678;
    do_read(3, d, v);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_after_write: got %h expected 12345678", d);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic v;
    int a;
    for (int k = 0; k < 60; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom(), BW'($urandom_range(0, 15)));
      end else begin
        do_read(a, d, v);
        checks++;
        if (d !== model[a] || v !== 1'b1) begin
          errors++;
          $display("FAIL random_read addr %0d: got %h valid %b expected %h valid 1", a, d, v, model[a]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    set_addr(a);
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if (rd_data !== model[a] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back addr %0d: got %h valid %b expected %h valid 1", a, rd_data, rd_valid, model[a]);
      end
      a = $urandom_range(0, DEPTH - 1);
      set_addr(a);
    end
    rd_en = 1'b0;
    cyc();
  endtask

  task automatic fill_nonzero();
    for (int a = 0; a < DEPTH; a++) do_write(a, $urandom() | 32'h1, 4'hF);
  endtask

  task automatic test_clear();
    logic [DW-1:0] d, held;
    logic v;
    int n;
    fill_nonzero();
    do_read(9, held, v);
    set_addr(2);
    wr_data = 32'h5555_5555; byte_en = 4'hF;
    clear = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: busy %b valid %b expected 1 0", busy, rd_valid);
    end
    n = 0;
    // Hammer the port with requests for the whole sweep; all must be lost.
    while (busy === 1'b1 && n < 100) begin
      set_addr($urandom_range(0, DEPTH - 1));
      wr_data = $urandom() | 32'h1; byte_en = 4'hF;
      wr_en = 1'b1; rd_en = 1'b1; clear = 1'($urandom_range(0, 1));
      cyc();
      n++;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== held) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: valid %b data %h expected 0 %h", n, rd_valid, rd_data, held);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_busy_cycles: got %0d expected 16", n);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    read_all_zero("clear_sweep_zero");
    do_read(2, d, v);
    checks++;
    if (d !== '0) begin
      errors++;
      $display("FAIL clear_drops_write: got %h expected 00000000", d);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [DW-1:0] held;
    logic v;
    int n;
    fill_nonzero();
    do_read(12, held, v);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (7) cyc();
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset_state: busy %b data %h valid %b expected 1 0 0", busy, rd_data, rd_valid);
    end
    cyc();
    cyc();
    reset_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL midsweep_busy_cycles: got %0d expected 16", n);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    read_all_zero("midsweep_zero");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    test_reset();
    test_byte_write();
    test_read_first();
    test_random();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_mem_mod.md
# param_mem_mod

Parametrised single-port word memory; the next-generation replacement for the fixed 1024×32 data and instruction memory banks. Adds configurable width and depth, per-byte write enables, a registered one-cycle read with a valid strobe, and a working memory clear: a hardware sweep that zeroes every word after reset or on request. It sits between the processor datapath (load/store and fetch paths) and the storage array, with `busy` telling the control unit when accesses are not accepted.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `ADDR_W`, 10, index bits; depth = 2^ADDR_W words.
- `CLEAR_ON_RESET`, 1, 1 = start a clear sweep when reset deasserts; 0 = go straight to IDLE.
- `clk`  in  1  single clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  request a full-memory zero sweep; sampled in IDLE only.
- `rd_en`  in  1  read request.
- `wr_en`  in  1  write request.
- `addr`  in  32  word address; only `addr[ADDR_W-1:0]` is used, upper bits ignored.
- `byte_en`  in  DATA_W/8  per-byte write mask; bit i covers `wr_data[8i+7:8i]`.
- `wr_data`  in  DATA_W  write data.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  one-cycle strobe: `rd_data` holds a fresh read.
- `busy`  out  1  high while clearing; requests ignored.

## Operation
- States: CLEAR, IDLE.
- Reset asserted: state = CLEAR if `CLEAR_ON_RESET`=1 else IDLE; sweep counter = 0; `rd_data` = 0; `rd_valid` = 0; `busy` = `CLEAR_ON_RESET`. The array itself is not asynchronously reset.
- CLEAR: each cycle writes 0 to word[counter] and increments the counter. On the cycle that writes word 2^ADDR_W−1, go to IDLE next cycle. The sweep takes exactly 2^ADDR_W cycles. `rd_en`, `wr_en` and `clear` are ignored; `rd_valid` = 0.
- IDLE, `clear`=1: go to CLEAR with counter = 0. Any `rd_en`/`wr_en` in that same cycle is dropped (clear wins).
- IDLE write: `wr_en`=1 updates the bytes of word[addr] whose `byte_en` bit is 1; other bytes are unchanged. `wr_en` with `byte_en`=0 is a no-op.
- IDLE read: `rd_en`=1 loads `rd_data` with word[addr] and pulses `rd_valid` on the next cycle. Without a read, `rd_data` holds its last value and `rd_valid` = 0.
- Read and write to the same address in the same cycle: read-first, so `rd_data` returns the pre-write contents. Different addresses cannot occur because the block is single-port.
- Reset asserted mid-sweep: restart the sweep from 0 (or go to IDLE when `CLEAR_ON_RESET`=0). A partially cleared array is acceptable in that case.

## Timing
- Read latency 1 cycle: request at edge N, data and `rd_valid` after edge N+1.
- Write takes effect at edge N and is visible to a read issued at N+1.
- `busy` is a registered output. It is high on every CLEAR cycle and falls on the edge that enters IDLE. The first accepted request is in the cycle `busy`=0.
- `clear` in IDLE raises `busy` on the next edge. Clear-to-ready takes 2^ADDR_W + 1 cycles.
- No back-pressure: requests made while `busy`=1 are lost. The master must gate requests on `busy`.

## Structure
- Shared package `mem_pkg`: state enum (`MS_IDLE`, `MS_CLEAR`), default `DATA_W`/`ADDR_W` constants, and the byte-count function `DATA_W/8`.
- Sub-module `mem_clear_fsm` owns the state register, sweep counter and `busy`. It provides the clear-write enable and address to the array muxing in the top level.
- Elaboration-time check: `DATA_W % 8 == 0`.

## Test plan
- Reset with `ADDR_W`=4, `CLEAR_ON_RESET`=1 -> `busy`=1 for exactly 16 cycles after `reset_n` rises. A read of each of the 16 words then returns 0 with `rd_valid` one cycle after `rd_en`.
- Write 0xDEADBEEF to addr 5 with `byte_en`=4'b1111, then 0x000000AA with `byte_en`=4'b0001 -> a read of addr 5 returns 0xDEADBEAA.
- Same-cycle write 0x12345678 and read at addr 3, where the word holds 0xCAFEF00D -> `rd_data`=0xCAFEF00D. A read the next cycle returns 0x12345678.
- Fill all words with non-zero data, pulse `clear` alongside a `wr_en` -> the write is dropped, `busy` is high for 16 cycles, and every word then reads 0.
- Pull `reset_n` low at sweep count 7 -> the counter restarts at 0, and a full 16-cycle `busy` follows deassertion.
- `rd_en`/`wr_en` while `busy`=1 -> no `rd_valid` pulse, and the array is unchanged after the sweep. Also check with `CLEAR_ON_RESET`=0: `busy`=0 immediately after reset.
